// File: rtl/embedded_system_mem_pkg.sv
// Shared definitions for the on-chip memory slave: clear-engine states and
// the supported read-latency range.
package embedded_system_mem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

endpackage

// File: rtl/embedded_system_onchip_memory_pipe_if.sv
// Avalon-MM slave bus bundle for the on-chip memory (request, response and
// back-pressure signals).
interface embedded_system_onchip_memory_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output chipselect, read, write, address, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  chipselect, read, write, address, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/embedded_system_ram_be.sv
// Byte-enabled single-port synchronous RAM, one-cycle registered read,
// write-first (a written lane reads back the new byte in the same cycle).
module embedded_system_ram_be #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64000,
  parameter int AW     = 16
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  // One narrow array per lane keeps each lane a plain inferable RAM.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we && be[gi]) begin
          mem[addr] <= wdata[gi*8 +: 8];
          rd_q      <= wdata[gi*8 +: 8];
        end else begin
          rd_q      <= mem[addr];
        end
      end
    end

    assign rdata[gi*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/embedded_system_onchip_memory_pipe.sv
// Parametrised on-chip RAM Avalon-MM slave: pipelined reads, waitrequest
// back-pressure, post-reset clear engine and out-of-range protection.
module embedded_system_onchip_memory_pipe
  import embedded_system_mem_pkg::*;
#(
  parameter int               DATA_W       = 32,
  parameter int               ADDR_W       = 16,
  parameter int               DEPTH        = 64000,
  parameter int               READ_LATENCY = 1,
  parameter int               CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_req,
  input  logic clken,
  embedded_system_onchip_memory_pipe_if.slave bus,
  output logic clear_busy
);

  localparam int               NB          = DATA_W / 8;
  localparam int               AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X     = (ADDR_W+1)'(DEPTH);
  localparam logic [AW-1:0]    LAST_IDX    = AW'(DEPTH - 1);
  localparam clr_state_e       RESET_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  logic              clocken;
  logic              wait_req;
  logic              in_range;
  logic              acc;
  logic              wr_acc;
  logic              rd_acc;
  clr_state_e        state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              v1_q, v1_d;
  logic              oor1_q, oor1_d;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [NB-1:0]     ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] s1_data;

  assign clocken         = clken & ~reset_req;
  assign clear_busy      = (state_q == ST_CLEAR);
  assign wait_req        = clear_busy | ~clocken;
  assign bus.waitrequest = wait_req;
  assign in_range        = ({1'b0, bus.address} < DEPTH_X);
  assign acc             = bus.chipselect & (bus.read | bus.write) & ~wait_req;
  assign wr_acc          = acc & bus.write;
  // A simultaneous read+write is treated as a write only.
  assign rd_acc          = acc & bus.read & ~bus.write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clocken && state_q == ST_CLEAR) begin
      if (cnt_q == LAST_IDX) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + AW'(1);
      end
    end
  end

  // The clear engine owns the RAM port; the bus is stalled meanwhile.
  always_comb begin
    if (clear_busy) begin
      ram_we    = 1'b1;
      ram_addr  = cnt_q;
      ram_be    = '1;
      ram_wdata = CLEAR_VALUE;
    end else begin
      ram_we    = wr_acc & in_range;
      ram_addr  = bus.address[AW-1:0];
      ram_be    = bus.byteenable;
      ram_wdata = bus.writedata;
    end
  end

  // The write lands in the array at its accepting edge, so a read accepted
  // on the following edge already sees the new word without a bypass path.
  embedded_system_ram_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .en    (clocken),
    .we    (ram_we),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    v1_d   = clocken ? rd_acc : v1_q;
    oor1_d = clocken ? (rd_acc & ~in_range) : oor1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      oor1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      oor1_q  <= oor1_d;
    end
  end

  assign s1_data = oor1_q ? '0 : ram_rdata;

  if (READ_LATENCY <= LAT_MIN) begin : g_lat1
    logic [DATA_W-1:0] last_q, last_d;
    logic              out_vld;

    // RAM output register is the last stage; last_q keeps readdata stable.
    assign out_vld           = v1_q & clocken;
    assign last_d            = out_vld ? s1_data : last_q;
    assign bus.readdatavalid = out_vld;
    assign bus.readdata      = out_vld ? s1_data : last_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) last_q <= '0;
      else       last_q <= last_d;
    end
  end else begin : g_lat2
    logic              v2_q, v2_d;
    logic [DATA_W-1:0] d2_q, d2_d;

    assign v2_d              = clocken ? v1_q : v2_q;
    assign d2_d              = (clocken & v1_q) ? s1_data : d2_q;
    assign bus.readdatavalid = v2_q & clocken;
    assign bus.readdata      = d2_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v2_d;
        d2_q <= d2_d;
      end
    end
  end

endmodule
